// File: rtl/mult_div_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer: captures operands on start, returns {hi,lo} with a done flag.
// Latency from start: mul MUL_LATENCY+1 cycles, div 34 cycles, divide-by-zero 1 cycle.
// Backpressure: hold keeps the result presented in DONE; flush abandons any operation in flight.
module mult_div_unit_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_div,
    input  logic                    is_signed,
    input  logic [DATA_WIDTH-1:0]   operand_1,
    input  logic [DATA_WIDTH-1:0]   operand_2,
    input  logic                    flush,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] result
);

    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (MUL_LATENCY > W) ? MUL_LATENCY : W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic               sgn_q, sgn_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [W-1:0]       quo_q, quo_d;
    logic [2*W-1:0]     result_q, result_d;

    logic [W-1:0]       abs_a_in;
    logic [W-1:0]       abs_b;
    logic [W:0]         shifted;
    logic [W:0]         trial;
    logic [2*W-1:0]     ext_a;
    logic [2*W-1:0]     ext_b;
    logic [2*W-1:0]     product;
    logic [W-1:0]       quo_fix;
    logic [W-1:0]       rem_fix;

    // Datapath helpers: magnitudes, divider trial subtraction, full-width product, sign fix-up
    always_comb begin
        abs_a_in = (is_signed && operand_1[W-1]) ? -operand_1 : operand_1;
        abs_b    = (sgn_q && op_b_q[W-1]) ? -op_b_q : op_b_q;
        shifted  = {rem_q, quo_q[W-1]};
        trial    = shifted - {1'b0, abs_b};
        ext_a    = sgn_q ? {{W{op_a_q[W-1]}}, op_a_q} : {{W{1'b0}}, op_a_q};
        ext_b    = sgn_q ? {{W{op_b_q[W-1]}}, op_b_q} : {{W{1'b0}}, op_b_q};
        product  = ext_a * ext_b;
        quo_fix  = (sgn_q && (op_a_q[W-1] ^ op_b_q[W-1])) ? -quo_q : quo_q;
        rem_fix  = (sgn_q && op_a_q[W-1]) ? -rem_q : rem_q;
    end

    // Next-state and register updates; flush overrides everything except reset
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sgn_d    = sgn_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d = operand_1;
                    op_b_d = operand_2;
                    sgn_d  = is_signed;
                    cnt_d  = '0;
                    if (!is_div) begin
                        state_d = S_MUL;
                    end else if (operand_2 == '0) begin
                        // Divide-by-zero short-circuits: dividend in hi, all-ones quotient in lo
                        state_d  = S_DONE;
                        result_d = {operand_1, {W{1'b1}}};
                    end else begin
                        state_d = S_DIV;
                        rem_d   = '0;
                        quo_d   = abs_a_in;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                    state_d  = S_DONE;
                    result_d = product;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                // When no subtraction happens the shifted remainder is below the divisor, so W bits hold it
                if (!trial[W]) begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = {rem_fix, quo_fix};
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sgn_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sgn_q    <= sgn_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mult_div_unit_ctrl.sv
// Self-checking bench for mult_div_unit_ctrl: directed cases plus randomized operations.
// Expected results come from plain integer arithmetic; latency counted from the start cycle.
// Exercises hold in DONE, flush mid-divide, and divide-by-zero / overflow corners.
module tb_mult_div_unit_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_div;
    logic        is_signed;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        hold;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

    mult_div_unit_ctrl #(.DATA_WIDTH(32), .MUL_LATENCY(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic with truncating division, wider than 32 bits so MIN/-1 wraps naturally
    function automatic logic [63:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic div, input logic sgn);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!div) begin
            res = 64'(sa * sb);
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFFFFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    function automatic int ref_latency(input logic [31:0] b, input logic div);
        if (!div) return MUL_LAT + 1;
        if (b == 32'd0) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h80000000;
            1: v = 32'hFFFFFFFF;
            2: v = 32'd0;
            3: v = 32'd1;
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issues one operation in the current (IDLE) cycle, scrambles inputs after capture, waits for done
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic div, input logic sgn, input logic [63:0] exp_res,
                          input int exp_lat, input logic back_to_idle);
        int cyc;
        operand_1 = a;
        operand_2 = b;
        is_div    = div;
        is_signed = sgn;
        start     = 1'b1;
        step();
        start     = 1'b0;
        operand_1 = $urandom;
        operand_2 = $urandom;
        is_div    = 1'($urandom);
        is_signed = 1'($urandom);
        cyc = 1;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        if (back_to_idle) begin
            step();
            chk({tag, " idle"}, 64'({busy, done}), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic        div, sgn;
        logic [63:0] prev;
        logic        saw_done;

        rst       = 1'b1;
        start     = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        flush     = 1'b0;
        hold      = 1'b0;
        repeat (3) step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        step();

        run_op("mult -3x5", 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 3, 1'b1);
        run_op("multu max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 3, 1'b1);
        run_op("div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 1'b1);
        run_op("divu 100/0", 32'd100, 32'd0, 1'b1, 1'b0, {32'd100, 32'hFFFFFFFF}, 1, 1'b1);
        run_op("div min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, {32'd0, 32'h80000000}, 34, 1'b1);

        // Flush a divide in cycle 10: IDLE in cycle 11, old result retained, done never rises
        prev      = result;
        operand_1 = 32'd1000;
        operand_2 = 32'd3;
        is_div    = 1'b1;
        is_signed = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush idle", 64'({busy, done}), 64'd0);
        chk("flush result kept", result, prev);
        saw_done = 1'b0;
        repeat (40) begin
            step();
            if (done) saw_done = 1'b1;
        end
        chk("flush no done", 64'(saw_done), 64'd0);
        run_op("divu 9/4", 32'd9, 32'd4, 1'b1, 1'b0, {32'd1, 32'd2}, 34, 1'b1);

        // Hold in DONE for 3 cycles with start asserted (must be ignored), then release
        hold = 1'b1;
        run_op("hold mul", 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start     = 1'b1;
            operand_1 = $urandom;
            operand_2 = $urandom;
            is_div    = 1'b1;
            step();
            chk("hold done", 64'(done), 64'd1);
            chk("hold result", result, 64'd42);
        end
        start = 1'b0;
        hold  = 1'b0;
        step();
        chk("hold release idle", 64'({busy, done}), 64'd0);
        run_op("after hold", 32'd12, 32'hFFFFFFFE, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFE8, 3, 1'b1);

        // Randomized operations against the arithmetic reference
        for (int n = 0; n < 24; n++) begin
            a   = pick_operand();
            b   = pick_operand();
            div = 1'($urandom);
            sgn = 1'($urandom);
            run_op($sformatf("rand%0d", n), a, b, div, sgn, ref_model(a, b, div, sgn),
                   ref_latency(b, div), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
